// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU issue/writeback sequencer.
package alu_sequencer_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned ALU_SEL_W  = 4;
    localparam int unsigned PSR_W      = 5;

    // PSR bit positions within {C,L,F,Z,N}
    localparam int unsigned PSR_C = 4;
    localparam int unsigned PSR_L = 3;
    localparam int unsigned PSR_F = 2;
    localparam int unsigned PSR_Z = 1;
    localparam int unsigned PSR_N = 0;

    // Operation codes: reg form uses op=0 with func, imm forms reuse func as op
    localparam logic [3:0] OP_REG = 4'b0000;
    localparam logic [3:0] FN_ADD = 4'b0101;
    localparam logic [3:0] FN_SUB = 4'b1001;
    localparam logic [3:0] FN_CMP = 4'b1011;
    localparam logic [3:0] FN_AND = 4'b0001;
    localparam logic [3:0] FN_OR  = 4'b0010;
    localparam logic [3:0] FN_XOR = 4'b0011;
    localparam logic [3:0] FN_MOV = 4'b1101;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_CMP  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_MOV  = 4'd6,
        ALU_MOVI = 4'd7
    } alu_sel_e;

    typedef enum logic [1:0] {
        FLG_KEEP  = 2'd0,
        FLG_ARITH = 2'd1,
        FLG_CMP   = 2'd2
    } flag_cls_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_e;

    typedef struct packed {
        alu_sel_e                sel;
        logic                    use_imm;
        logic [DATA_W-1:0]       imm;
        logic [REG_ADDR_W-1:0]   rdest;
        logic [REG_ADDR_W-1:0]   rsrc;
        logic                    writes;
        flag_cls_e               cls;
        logic                    illegal;
    } dec_t;

    // Merge captured ALU flags into the PSR according to the instruction class
    function automatic logic [PSR_W-1:0] psr_update(input logic [PSR_W-1:0] cur,
                                                    input flag_cls_e cls,
                                                    input logic [PSR_W-1:0] flg);
        logic [PSR_W-1:0] nxt;
        nxt = cur;
        case (cls)
            FLG_ARITH: begin
                nxt[PSR_C] = flg[PSR_C];
                nxt[PSR_F] = flg[PSR_F];
            end
            FLG_CMP: begin
                nxt[PSR_L] = flg[PSR_L];
                nxt[PSR_Z] = flg[PSR_Z];
                nxt[PSR_N] = flg[PSR_N];
            end
            default: ;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational instruction decoder: word -> ALU select, operands, immediate, class.
module alu_sequencer_decode
    import alu_sequencer_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output dec_t               dec
);

    logic [3:0] op;
    logic [3:0] code;
    logic       imm_form;
    logic       known;
    logic       sext;
    alu_sel_e   sel;
    flag_cls_e  cls;
    logic       writes;

    // Decode; unknown words produce an all-zero record with only illegal set
    always_comb begin
        dec      = '0;
        op       = instr[15:12];
        imm_form = (op != OP_REG);
        code     = imm_form ? op : instr[7:4];
        known    = 1'b1;
        sext     = 1'b0;
        sel      = ALU_ADD;
        cls      = FLG_KEEP;
        writes   = 1'b1;
        case (code)
            FN_ADD: begin sel = ALU_ADD; cls = FLG_ARITH; sext = 1'b1; end
            FN_SUB: begin sel = ALU_SUB; cls = FLG_ARITH; sext = 1'b1; end
            FN_CMP: begin sel = ALU_CMP; cls = FLG_CMP; sext = 1'b1; writes = 1'b0; end
            FN_AND: sel = ALU_AND;
            FN_OR:  sel = ALU_OR;
            FN_XOR: sel = ALU_XOR;
            FN_MOV: sel = imm_form ? ALU_MOVI : ALU_MOV;
            default: known = 1'b0;
        endcase
        if (known) begin
            dec.sel     = sel;
            dec.use_imm = imm_form;
            if (imm_form) begin
                dec.imm = sext ? DATA_W'($signed(instr[7:0])) : DATA_W'(instr[7:0]);
            end
            dec.rdest   = instr[11:8];
            dec.rsrc    = instr[3:0];
            dec.writes  = writes;
            dec.cls     = cls;
        end else begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback sequencer around the ALU: one instruction in flight, 4-cycle cadence.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [INSTR_W-1:0]    instr,
    output logic                  instr_ready,
    input  logic                  flush,
    output logic [ALU_SEL_W-1:0]  aluControl,
    output logic [REG_ADDR_W-1:0] rfAddrA,
    output logic [REG_ADDR_W-1:0] rfAddrB,
    output logic [DATA_W-1:0]     immOut,
    output logic                  useImm,
    input  logic [DATA_W-1:0]     aluResult,
    input  logic                  aluC,
    input  logic                  aluL,
    input  logic                  aluF,
    input  logic                  aluZ,
    input  logic                  aluN,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] wbAddr,
    output logic [DATA_W-1:0]     wbData,
    output logic [PSR_W-1:0]      psr,
    output logic                  done,
    output logic                  illegal
);

    state_e           state;
    dec_t             dec_c;
    dec_t             dec_q;
    logic [PSR_W-1:0] flags_q;
    logic             we_q;
    logic             done_q;
    logic             ill_q;

    alu_sequencer_decode u_decode (
        .instr (instr),
        .dec   (dec_c)
    );

    // Decode fields are held from DECODE through WRITEBACK
    assign aluControl  = dec_q.sel;
    assign rfAddrA     = dec_q.rdest;
    assign rfAddrB     = dec_q.rsrc;
    assign immOut      = dec_q.imm;
    assign useImm      = dec_q.use_imm;
    assign instr_ready = (state == S_IDLE);

    // A flush during WRITEBACK cancels the strobes in that same cycle
    assign regWrite = we_q   & ~flush;
    assign done     = done_q & ~flush;
    assign illegal  = ill_q  & ~flush;

    // Sequencer FSM with instruction, result and PSR registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            dec_q   <= '0;
            flags_q <= '0;
            wbAddr  <= '0;
            wbData  <= '0;
            psr     <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            ill_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid && !flush) begin
                        dec_q <= dec_c;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (dec_q.illegal) begin
                        done_q <= 1'b1;
                        ill_q  <= 1'b1;
                        state  <= S_WRITEBACK;
                    end else begin
                        state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        wbData  <= aluResult;
                        flags_q <= {aluC, aluL, aluF, aluZ, aluN};
                        wbAddr  <= dec_q.rdest;
                        we_q    <= dec_q.writes;
                        done_q  <= 1'b1;
                        state   <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    if (!flush) begin
                        psr <= psr_update(psr, dec_q.cls, flags_q);
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: vector table plus flush/reset corner sequences.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic        flush;
    logic [3:0]  aluControl;
    logic [3:0]  rfAddrA;
    logic [3:0]  rfAddrB;
    logic [15:0] immOut;
    logic        useImm;
    logic [15:0] aluResult;
    logic        aluC, aluL, aluF, aluZ, aluN;
    logic        regWrite;
    logic [3:0]  wbAddr;
    logic [15:0] wbData;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;

    int total = 0;
    int bad   = 0;
    logic [4:0] psr_m;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] res;
        logic [4:0]  flg;
        logic [3:0]  sel;
        logic        uimm;
        logic [15:0] imm;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        we;
        logic        ill;
        logic [1:0]  cls;
    } vec_t;

    vec_t vecs[12];

    alu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .flush       (flush),
        .aluControl  (aluControl),
        .rfAddrA     (rfAddrA),
        .rfAddrB     (rfAddrB),
        .immOut      (immOut),
        .useImm      (useImm),
        .aluResult   (aluResult),
        .aluC        (aluC),
        .aluL        (aluL),
        .aluF        (aluF),
        .aluZ        (aluZ),
        .aluN        (aluN),
        .regWrite    (regWrite),
        .wbAddr      (wbAddr),
        .wbData      (wbData),
        .psr         (psr),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference PSR merge: {C,L,F,Z,N}; cls 1 = C,F only, cls 2 = L,Z,N only
    task automatic model_psr(input logic [1:0] cls, input logic [4:0] flg);
        if (cls == 2'd1) begin
            psr_m[4] = flg[4];
            psr_m[2] = flg[2];
        end else if (cls == 2'd2) begin
            psr_m[3] = flg[3];
            psr_m[1] = flg[1];
            psr_m[0] = flg[0];
        end
    endtask

    // Transfer one word and leave the bench in the DECODE cycle with ALU inputs driven
    task automatic issue(input logic [15:0] w, input logic [15:0] res, input logic [4:0] flg);
        int n;
        n = 0;
        while (!instr_ready && n < 8) begin
            tick();
            n++;
        end
        chk("ready_wait", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = w;
        tick();
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        aluResult   = res;
        {aluC, aluL, aluF, aluZ, aluN} = flg;
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.instr, v.res, v.flg);
        chk("dec_sel",   32'(aluControl), 32'(v.sel));
        chk("dec_uimm",  32'(useImm),     32'(v.uimm));
        chk("dec_imm",   32'(immOut),     32'(v.imm));
        chk("dec_ra",    32'(rfAddrA),    32'(v.ra));
        chk("dec_rb",    32'(rfAddrB),    32'(v.rb));
        chk("dec_ready", 32'(instr_ready), 32'd0);
        chk("dec_done",  32'(done),        32'd0);
        if (!v.ill) begin
            tick();
            chk("ex_we",   32'(regWrite), 32'd0);
            chk("ex_done", 32'(done),     32'd0);
            instr_valid = 1'b1;
            instr       = 16'h0152;
        end
        tick();
        instr_valid = 1'b0;
        chk("wb_we",   32'(regWrite), 32'(v.we));
        chk("wb_done", 32'(done),     32'd1);
        chk("wb_ill",  32'(illegal),  32'(v.ill));
        if (v.we) begin
            chk("wb_addr", 32'(wbAddr), 32'(v.ra));
            chk("wb_data", 32'(wbData), 32'(v.res));
        end
        chk("wb_psr_old", 32'(psr), 32'(psr_m));
        model_psr(v.cls, v.flg);
        tick();
        chk("idle_ready", 32'(instr_ready), 32'd1);
        chk("idle_done",  32'(done),        32'd0);
        chk("idle_we",    32'(regWrite),    32'd0);
        chk("idle_psr",   32'(psr),         32'(psr_m));
        chk("idle_sel",   32'(aluControl),  32'(v.sel));
    endtask

    initial begin
        //          instr     res       flg       sel  uimm imm       ra    rb    we ill cls
        vecs[0]  = '{16'h0152, 16'h0001, 5'b10100, 4'd0, 1'b0, 16'h0000, 4'h1, 4'h2, 1, 0, 2'd1};
        vecs[1]  = '{16'hB3FF, 16'h0006, 5'b11101, 4'd2, 1'b1, 16'hFFFF, 4'h3, 4'hF, 0, 0, 2'd2};
        vecs[2]  = '{16'h1480, 16'h0080, 5'b11111, 4'd3, 1'b1, 16'h0080, 4'h4, 4'h0, 1, 0, 2'd0};
        vecs[3]  = '{16'hF000, 16'h0000, 5'b11111, 4'd0, 1'b0, 16'h0000, 4'h0, 4'h0, 0, 1, 2'd0};
        vecs[4]  = '{16'h0A21, 16'h1234, 5'b00000, 4'd4, 1'b0, 16'h0000, 4'hA, 4'h1, 1, 0, 2'd0};
        vecs[5]  = '{16'h95F0, 16'h0010, 5'b01011, 4'd1, 1'b1, 16'hFFF0, 4'h5, 4'h0, 1, 0, 2'd1};
        vecs[6]  = '{16'hD7AB, 16'h00AB, 5'b10110, 4'd7, 1'b1, 16'h00AB, 4'h7, 4'hB, 1, 0, 2'd0};
        vecs[7]  = '{16'h0C63, 16'h0000, 5'b11111, 4'd0, 1'b0, 16'h0000, 4'h0, 4'h0, 0, 1, 2'd0};
        vecs[8]  = '{16'h0ED4, 16'hBEEF, 5'b00000, 4'd6, 1'b0, 16'h0000, 4'hE, 4'h4, 1, 0, 2'd0};
        vecs[9]  = '{16'h3880, 16'h5555, 5'b11111, 4'd5, 1'b1, 16'h0080, 4'h8, 4'h0, 1, 0, 2'd0};
        vecs[10] = '{16'h5FFF, 16'h0000, 5'b10011, 4'd0, 1'b1, 16'hFFFF, 4'hF, 4'hF, 1, 0, 2'd1};
        vecs[11] = '{16'hBA20, 16'h0000, 5'b00010, 4'd2, 1'b1, 16'h0020, 4'hA, 4'h0, 0, 0, 2'd2};

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        flush       = 1'b0;
        aluResult   = 16'h0000;
        {aluC, aluL, aluF, aluZ, aluN} = 5'b00000;
        psr_m       = 5'b00000;
        tick();
        tick();
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_we",    32'(regWrite),    32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_psr",   32'(psr),         32'd0);
        chk("rst_sel",   32'(aluControl),  32'd0);
        chk("rst_imm",   32'(immOut),      32'd0);
        chk("rst_wbd",   32'(wbData),      32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // flush in EXECUTE: nothing retires, PSR untouched
        issue(16'h0152, 16'h7777, 5'b11111);
        tick();
        flush = 1'b1;
        #1;
        chk("flex_we",   32'(regWrite), 32'd0);
        chk("flex_done", 32'(done),     32'd0);
        tick();
        flush = 1'b0;
        chk("flex_ready", 32'(instr_ready), 32'd1);
        chk("flex_psr",   32'(psr),         32'(psr_m));
        tick();
        chk("flex_done2", 32'(done), 32'd0);

        // flush in WRITEBACK: strobes masked that cycle, PSR untouched
        issue(16'h0152, 16'h7777, 5'b11111);
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("flwb_we",   32'(regWrite), 32'd0);
        chk("flwb_done", 32'(done),     32'd0);
        tick();
        flush = 1'b0;
        chk("flwb_ready", 32'(instr_ready), 32'd1);
        chk("flwb_psr",   32'(psr),         32'(psr_m));

        // flush in IDLE drops a simultaneous transfer
        flush       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h0152;
        tick();
        flush       = 1'b0;
        instr_valid = 1'b0;
        chk("flid_ready", 32'(instr_ready), 32'd1);
        tick();
        tick();
        chk("flid_ready2", 32'(instr_ready), 32'd1);
        chk("flid_done",   32'(done),        32'd0);

        // reset in WRITEBACK clears everything from that edge onward
        issue(16'h0152, 16'h00AA, 5'b00000);
        tick();
        tick();
        chk("rwb_we_pre", 32'(regWrite), 32'd1);
        chk("rwb_psr",    32'(psr),      32'(psr_m));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        psr_m = 5'b00000;
        chk("rwb_we",    32'(regWrite),    32'd0);
        chk("rwb_done",  32'(done),        32'd0);
        chk("rwb_psr0",  32'(psr),         32'd0);
        chk("rwb_ready", 32'(instr_ready), 32'd1);
        chk("rwb_ra",    32'(rfAddrA),     32'd0);
        chk("rwb_wbd",   32'(wbData),      32'd0);
        chk("rwb_wba",   32'(wbAddr),      32'd0);
        tick();
        chk("rwb_psr1", 32'(psr), 32'd0);

        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
